// File: rtl/fifo_pkg.sv
// Shared constants for the parameterised FIFO: default geometry and full-handling modes.
package fifo_pkg;
  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 3;
  localparam int FM_REJECT    = 0;
  localparam int FM_OVERWRITE = 1;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DW storage: one synchronous write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Array is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Same-address read/write returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (reset)   rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: pointer/count control, status flags and error pulse
// around a fifo_mem storage block. Full handling selectable between reject and overwrite.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int FULL_MODE = FM_REJECT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] data_in,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [AW:0]   count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          error
);
  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam bit          OVW     = (FULL_MODE == FM_OVERWRITE);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          pop_ok, push_ok, ovw, rd_adv, err_nxt;

  // Status depends only on the registered count and the live thresholds.
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (count >= umbral_almost_full);
  assign almost_empty = (count <= umbral_almost_empty);

  assign pop_ok  = pop && !fifo_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still takes the push.
  assign push_ok = push && (!fifo_full || pop || OVW);
  assign ovw     = OVW && push && fifo_full && !pop;
  assign rd_adv  = pop_ok || ovw;
  assign err_nxt = (pop && fifo_empty) || (push && fifo_full && !pop);

  always_comb begin
    count_nxt = count;
    if (push_ok && !rd_adv)      count_nxt = count + CNT_ONE;
    else if (rd_adv && !push_ok) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv)  rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      valid_out <= pop_ok;
      error     <= err_nxt;
    end
  end

  fifo_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (push_ok && !reset),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .re      (pop_ok && !reset),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );
endmodule
